// File: rtl/universal_reg.sv
// rtl/universal_reg.sv - parameterised universal shift/rotate/count register
// Registers q, sout and ovf; every op decodes to a defined next state.
module universal_reg #(
  parameter int p_nbits = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [2:0]         op,
  input  logic [p_nbits-1:0] d,
  input  logic               sin,
  output logic [p_nbits-1:0] q,
  output logic               sout,
  output logic               ovf
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_SHL  = 3'd2,
    OP_SHR  = 3'd3,
    OP_ROTL = 3'd4,
    OP_ROTR = 3'd5,
    OP_INC  = 3'd6,
    OP_DEC  = 3'd7
  } op_t;

  logic [p_nbits-1:0] r_q;
  logic               r_sout;
  logic               r_ovf;

  logic [p_nbits-1:0] w_q_nxt;
  logic               w_sout_nxt;
  logic               w_ovf_nxt;
  logic               w_all_ones;
  logic               w_all_zero;

  assign w_all_ones = &r_q;
  assign w_all_zero = ~|r_q;

  // sout/ovf only change on the ops that own them; everything else retains.
  always_comb begin
    w_q_nxt    = r_q;
    w_sout_nxt = r_sout;
    w_ovf_nxt  = r_ovf;
    case (op_t'(op))
      OP_HOLD: ;
      OP_LOAD: w_q_nxt = d;
      OP_SHL: begin
        w_q_nxt    = {r_q[p_nbits-2:0], sin};
        w_sout_nxt = r_q[p_nbits-1];
      end
      OP_SHR: begin
        w_q_nxt    = {sin, r_q[p_nbits-1:1]};
        w_sout_nxt = r_q[0];
      end
      OP_ROTL: begin
        w_q_nxt    = {r_q[p_nbits-2:0], r_q[p_nbits-1]};
        w_sout_nxt = r_q[p_nbits-1];
      end
      OP_ROTR: begin
        w_q_nxt    = {r_q[0], r_q[p_nbits-1:1]};
        w_sout_nxt = r_q[0];
      end
      OP_INC: begin
        w_q_nxt   = r_q + 1'b1;
        w_ovf_nxt = w_all_ones;
      end
      OP_DEC: begin
        w_q_nxt   = r_q - 1'b1;
        w_ovf_nxt = w_all_zero;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= '0;
      r_sout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (en) begin
      r_q    <= w_q_nxt;
      r_sout <= w_sout_nxt;
      r_ovf  <= w_ovf_nxt;
    end
  end

  assign q    = r_q;
  assign sout = r_sout;
  assign ovf  = r_ovf;

endmodule
